// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb
// Purpose  : 32-entry register file with a one-deep write-back commit stage.
//            A write is captured in a pending slot on one edge and committed
//            to the array on the next edge. Two combinational read ports
//            bypass from the incoming write and from the pending slot, so
//            readers never see stale data. Register 0 is hardwired to zero.
// Ports    : clk, rst_n (async, active-low)
//            wb_en/wb_addr/wb_data     - write-back request
//            rs_addr/rs_data           - read port A (combinational)
//            rt_addr/rt_data           - read port B (combinational)
//            pend_valid                - pending slot holds a write
//            commit_count              - writes committed (wraps silently)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              pend_valid,
    output logic [31:0]       commit_count
);

    localparam int C_NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [C_NREG];
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_pend_valid;
    logic [31:0]       r_commit_count;

    // Writes to register 0 are dropped before they reach the pending slot,
    // so the commit path never needs to filter address 0 itself.
    logic w_capture;
    assign w_capture = wb_en && (wb_addr != '0);

    // Pending slot: refilled every edge a valid write arrives, otherwise
    // emptied. Address/data hold their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= w_capture;
            if (w_capture) begin
                r_pend_addr <= wb_addr;
                r_pend_data <= wb_data;
            end
        end
    end

    // Commit runs on the same edge as capture, independently, giving one
    // write per cycle throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_commit_count <= '0;
        end else if (r_pend_valid) begin
            r_regs[r_pend_addr] <= r_pend_data;
            r_commit_count      <= r_commit_count + 32'd1;
        end
    end

    // Read port A: zero register, then incoming write, then pending slot,
    // then the array. The incoming write wins because it is the younger one.
    always_comb begin
        rs_data = r_regs[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_en && (wb_addr == rs_addr)) begin
            rs_data = wb_data;
        end else if (r_pend_valid && (r_pend_addr == rs_addr)) begin
            rs_data = r_pend_data;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rt_data = r_regs[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_en && (wb_addr == rt_addr)) begin
            rt_data = wb_data;
        end else if (r_pend_valid && (r_pend_addr == rt_addr)) begin
            rt_data = r_pend_data;
        end
    end

    assign pend_valid   = r_pend_valid;
    assign commit_count = r_commit_count;

endmodule
`default_nettype wire
